// File: rtl/mister_video_pkg.sv
// mister_video_pkg: shared line-buffer writer states, line RAM size and pixel field offsets
package mister_video_pkg;
  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} lbuf_state_t;
  localparam int LRAM_WORDS = 1024;
  localparam int PIX_G_HI = 15;
  localparam int PIX_G_LO = 11;
  localparam int PIX_R_HI = 10;
  localparam int PIX_R_LO = 6;
  localparam int PIX_B_HI = 5;
  localparam int PIX_B_LO = 1;
  localparam int PIX_I = 0;
endpackage

// File: rtl/mister_lbuf_writer.sv
// mister_lbuf_writer: fills the released line RAM bank from a valid/ready pixel stream each line (optional LBUF_PIXDBL_EN: horizontal pixel doubling)
module mister_lbuf_writer
  import mister_video_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W = 8
) (
  input  logic              gclk,
  input  logic              rst,
  input  logic              HCOMP,
  input  logic              VPSTART,
  input  logic              LRAMSEL,
  input  logic [10:0]       line_len,
  input  logic              pix_dbl,
  output logic              line_req,
  output logic [ADDR_W-1:0] line_num,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [15:0]       src_data,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_adr,
  output logic [15:0]       wr_dat,
  output logic              line_done,
  output logic              underrun,
  output logic [CNT_W-1:0]  underrun_cnt
);
  lbuf_state_t state_q, state_d;
  logic bank_q, bank_d, wbank_q, wbank_d;
  logic [ADDR_W-1:0] line_num_q, line_num_d, cnt_q, cnt_d, lm1_q, lm1_d, wr_adr_q, wr_adr_d;
  logic [15:0] wr_dat_q, wr_dat_d;
  logic wr_en_q, wr_en_d, line_done_q, line_done_d, underrun_q, underrun_d;
  logic half_q, half_d, dbl_q, dbl_d;
  logic [CNT_W-1:0] ucnt_q, ucnt_d;
  logic hs, issue, last, urun;
`ifdef LBUF_PIXDBL_EN
  assign dbl_d = HCOMP ? pix_dbl : dbl_q;
`else
  logic unused_pix_dbl;
  assign unused_pix_dbl = pix_dbl;
  assign dbl_d = 1'b0;
`endif
  assign src_ready = (state_q == FILL) && !half_q;
  assign line_req = state_q == REQ;
  assign line_num = line_num_q;
  assign wr_en = wr_en_q;
  // a final write that coincides with HCOMP must still land in the bank it was issued for
  assign wr_bank = wr_en_q ? wbank_q : bank_q;
  assign wr_adr = wr_adr_q;
  assign wr_dat = wr_dat_q;
  assign line_done = line_done_q;
  assign underrun = underrun_q;
  assign underrun_cnt = ucnt_q;
  always_comb begin
    hs = src_valid && src_ready;
    issue = (state_q == FILL) && (hs || half_q);
    last = issue && (cnt_q == lm1_q);
    urun = HCOMP && ((state_q == REQ) || ((state_q == FILL) && !last));
    state_d = state_q;
    bank_d = bank_q;
    wbank_d = wbank_q;
    line_num_d = line_num_q;
    cnt_d = cnt_q;
    lm1_d = lm1_q;
    wr_adr_d = wr_adr_q;
    wr_dat_d = wr_dat_q;
    wr_en_d = 1'b0;
    line_done_d = 1'b0;
    underrun_d = underrun_q;
    ucnt_d = ucnt_q;
    half_d = 1'b0;
    if (state_q == REQ) begin
      cnt_d = '0;
      state_d = FILL;
    end
    if (issue) begin
      wr_en_d = 1'b1;
      wr_adr_d = cnt_q;
      wr_dat_d = half_q ? wr_dat_q : src_data;
      wbank_d = bank_q;
      cnt_d = cnt_q + 1'b1;
      line_done_d = last;
      half_d = hs && dbl_q && !last;
      state_d = last ? DONE : FILL;
    end
    if (HCOMP) begin
      bank_d = LRAMSEL;
      line_num_d = VPSTART ? '0 : line_num_q + 1'b1;
      lm1_d = (line_len > 11'(LRAM_WORDS)) ? '1 : ADDR_W'(line_len - 11'd1);
      state_d = (line_len == '0) ? DONE : REQ;
      half_d = 1'b0;
      if (urun) begin
        wr_en_d = 1'b0;
        line_done_d = 1'b0;
        underrun_d = 1'b1;
        ucnt_d = &ucnt_q ? ucnt_q : ucnt_q + 1'b1;
      end
    end
  end
  always_ff @(posedge gclk) begin
    if (rst) begin
      state_q <= IDLE;
      bank_q <= 1'b0;
      wbank_q <= 1'b0;
      line_num_q <= '0;
      cnt_q <= '0;
      lm1_q <= '0;
      wr_adr_q <= '0;
      wr_dat_q <= '0;
      wr_en_q <= 1'b0;
      line_done_q <= 1'b0;
      underrun_q <= 1'b0;
      ucnt_q <= '0;
      half_q <= 1'b0;
      dbl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q <= bank_d;
      wbank_q <= wbank_d;
      line_num_q <= line_num_d;
      cnt_q <= cnt_d;
      lm1_q <= lm1_d;
      wr_adr_q <= wr_adr_d;
      wr_dat_q <= wr_dat_d;
      wr_en_q <= wr_en_d;
      line_done_q <= line_done_d;
      underrun_q <= underrun_d;
      ucnt_q <= ucnt_d;
      half_q <= half_d;
      dbl_q <= dbl_d;
    end
  end
endmodule

// File: doc/mister_lbuf_writer.md
Name: mister_lbuf_writer

Overview:
Producer side of the double-buffered line RAM that mister_sync scans out. On each line-start pulse it latches the bank the scan-out has just released and requests the next line from the pixel source. It then accepts a valid/ready pixel stream and writes it into that bank at addresses 0..len-1. It sits between the layer compositor (the pixel source) and the 2x1024x16 line RAM.

Parameters:
ADDR_W, 10, line RAM address width (1024 words per bank)
CNT_W, 8, width of the saturating underrun counter

Ports:
gclk  in  1  system clock (80 MHz domain)
rst  in  1  synchronous, active-high reset
HCOMP  in  1  one-cycle line-start pulse from the sync generator
VPSTART  in  1  one-cycle frame-start pulse; coincides with HCOMP of line 0
LRAMSEL  in  1  bank currently selected by the scan-out (value before toggle)
line_len  in  11  pixels per line; values >1024 clamp to 1024
pix_dbl  in  1  horizontal doubling request (used only with LBUF_PIXDBL_EN)
line_req  out  1  one-cycle request pulse to the pixel source
line_num  out  10  line number that accompanies line_req
src_valid  in  1  source pixel valid
src_ready  out  1  writer ready
src_data  in  16  pixel, line RAM format {G[4:0],R[4:0],B[4:0],I}
wr_en  out  1  line RAM write strobe
wr_bank  out  1  line RAM bank select for writes
wr_adr  out  10  line RAM write address
wr_dat  out  16  line RAM write data
line_done  out  1  one-cycle pulse when the last pixel is written
underrun  out  1  sticky: HCOMP arrived before the line completed
underrun_cnt  out  CNT_W  saturating count of underruns

Behaviour:
- Reset values: state IDLE; all outputs 0. The line counter resets to 0.
- States: IDLE, REQ, FILL, DONE.
- IDLE: src_ready=0. On HCOMP:
  - wr_bank <= LRAMSEL. The reader toggles on that same edge, so the writer always targets the bank being released.
  - Line counter: if VPSTART, line_num <= 0; else line_num <= line_num+1, wrapping 1023->0.
  - Go to REQ. If the clamped len is 0, go to DONE instead, with no request and no line_done.
- REQ: line_req=1 for exactly one cycle with line_num stable. Pixel address counter cleared. Next state FILL.
- FILL: src_ready=1.
  - A handshake is src_valid&&src_ready.
  - The next cycle has wr_en=1, wr_adr=counter, wr_dat=src_data. Write latency is 1 cycle, fully registered.
  - The counter increments per write.
  - When the write to address len-1 is issued, line_done pulses in the same cycle as that wr_en. src_ready drops the following cycle; state goes to DONE.
- DONE: src_ready=0; wait for HCOMP and handle it as in IDLE.
- HCOMP in REQ or FILL (underrun):
  - The current line is abandoned and any pending registered write is suppressed. Stale words remain in the old bank.
  - underrun <= 1 (sticky; cleared only by rst). underrun_cnt increments, saturating at 2^CNT_W-1.
  - The new line starts immediately as in IDLE.
- HCOMP and the final handshake in the same cycle: the final write completes and line_done pulses; this is not an underrun. The new line then begins.
- line_num and wr_bank are held constant from REQ until the next HCOMP.
- Extra src_valid outside FILL is ignored (ready=0).
- rst mid-line: immediate return to IDLE; wr_en is deasserted in the next cycle.

Optional Feature:
LBUF_PIXDBL_EN
- Defined:
  - While pix_dbl (sampled at HCOMP) is 1, each accepted pixel is written to two consecutive addresses on two consecutive cycles.
  - src_ready is 0 during the second write.
  - The source supplies ceil(len/2) pixels. If len is odd, the final pixel is written once.
- Undefined: pix_dbl is ignored; one write per pixel.

Decomposition:
- Shared package mister_video_pkg:
  - state enum lbuf_state_t {IDLE,REQ,FILL,DONE}
  - constant LRAM_WORDS=1024
  - pixel field offsets (G 15:11, R 10:6, B 5:1, I 0)
- No sub-module; a single FSM plus counters.

Test Plan:
- Reset, then HCOMP with LRAMSEL=1, line_len=512, src_valid held high -> line_req one cycle after HCOMP. 512 writes to bank 1, addresses 0..511, consecutive. line_done coincides with the write to addr 511. underrun=0.
- VPSTART+HCOMP, then 3 more HCOMPs -> line_num sequence 0,1,2,3. Starting from line_num=1023 with no VPSTART -> wraps to 0.
- line_len=256, source stalls after 100 pixels, HCOMP arrives -> underrun=1, underrun_cnt=1, no write past addr 99. A new line_req follows for the next line on the opposite bank.
- line_len=1500 -> clamps: exactly 1024 writes, last at addr 1023. line_len=0 -> no line_req, no writes.
- Random src_valid bubbles at 30% duty, line_len=768 -> written data equals the source sequence in order, with no gaps in wr_adr.
- With LBUF_PIXDBL_EN, pix_dbl=1, line_len=5 -> source pixels A,B,C accepted. Writes are A,A,B,B,C at addrs 0..4; src_ready low on every second cycle.
